// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants, frame FSM states and musical key table
// Purpose: common definitions for the PS/2 receive front end and key tracker.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] VOICE_IDLE = 8'hF0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  // Two rows of the keyboard mapped onto a chromatic range.
  function automatic logic is_music_key(input logic [7:0] code);
    case (code)
      8'h15, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h43, 8'h44, 8'h4D, 8'h5B, 8'h52,
      8'h4C, 8'h4B, 8'h42, 8'h3B, 8'h33, 8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C:
        is_music_key = 1'b1;
      default:
        is_music_key = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 clock filter, frame receiver and timeout
// Purpose: synchronise and filter ps2_clk, shift in 11-bit frames, check them.
// Ports: sys_clk/reset (async, active high); ps2_clk/ps2_dat raw inputs;
//        scandata last good byte; scan_valid/parity_err/frame_err one-cycle pulses.
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scandata,
  output logic       scan_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic          r_fall;
  logic          r_fall_dat;
  frame_state_t  r_state;
  frame_state_t  w_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_scandata;
  logic          w_change_done;
  logic          w_timeout;
  logic          w_scan_valid;
  logic          w_parity_err;
  logic          w_frame_err;

  // Filter accepts a new level only after FILTER_LEN consecutive differing samples.
  assign w_change_done = (r_clk_s[1] != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_filt     <= 1'b1;
      r_fcnt     <= '0;
      r_fall     <= 1'b0;
      r_fall_dat <= 1'b1;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_dat};
      if (r_clk_s[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (w_change_done) begin
        r_fcnt <= '0;
        r_filt <= r_clk_s[1];
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
      // Data bit travels alongside the fall strobe so both are aligned.
      r_fall     <= w_change_done && !r_clk_s[1];
      r_fall_dat <= r_dat_s[1];
    end
  end

  assign w_timeout = (r_state != FR_IDLE) && !r_fall &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next       = r_state;
    w_scan_valid = 1'b0;
    w_parity_err = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      FR_IDLE: begin
        if (r_fall) begin
          if (!r_fall_dat) w_next = FR_DATA;
          else             w_frame_err = 1'b1;
        end
      end
      FR_DATA: begin
        if (r_fall && (r_bitcnt == 3'd7)) w_next = FR_PARITY;
      end
      FR_PARITY: begin
        if (r_fall) w_next = FR_STOP;
      end
      FR_STOP: begin
        if (r_fall) begin
          w_next = FR_IDLE;
          if (!r_fall_dat)             w_frame_err  = 1'b1;
          else if (^{r_shift, r_par})  w_scan_valid = 1'b1;
          else                         w_parity_err = 1'b1;
        end
      end
      default: w_next = FR_IDLE;
    endcase
    if (w_timeout) begin
      w_next      = FR_IDLE;
      w_frame_err = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= FR_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      r_scandata <= '0;
    end else begin
      r_state  <= w_next;
      r_to_cnt <= (r_state == FR_IDLE || r_fall) ? '0 : r_to_cnt + 1'b1;
      if (r_state == FR_IDLE) r_bitcnt <= '0;
      if (r_fall && (r_state == FR_DATA)) begin
        r_shift  <= {r_fall_dat, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (r_fall && (r_state == FR_PARITY)) r_par <= r_fall_dat;
      if (w_scan_valid) r_scandata <= r_shift;
    end
  end

  // Present the new byte during the scan_valid pulse itself.
  assign scandata   = w_scan_valid ? r_shift : r_scandata;
  assign scan_valid = w_scan_valid;
  assign parity_err = w_parity_err;
  assign frame_err  = w_frame_err;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 keyboard front end with polyphonic voice table
// Purpose: decode make/break/extended codes and assign held music keys to slots.
// Ports: sys_clk/reset (async, active high); ps2_clk/ps2_dat raw PS/2 lines;
//        all_off releases every voice; scandata/scan_valid/parity_err/frame_err
//        from the receiver; voice_on per-slot flag; voice_code 8 bits per slot.
module ps2_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter int NUM_VOICES     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int STEAL          = 0
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_dat,
  input  logic                    all_off,
  output logic [7:0]              scandata,
  output logic                    scan_valid,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [8*NUM_VOICES-1:0] voice_code
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0]       r_on;
  logic [NUM_VOICES-1:0][7:0]  r_code;
  logic                        r_break_pend;
  logic                        r_ext_pend;
  logic [IW-1:0]               r_steal_ptr;
  logic                        w_free_found;
  logic [IW-1:0]               w_free_idx;
  logic                        w_held;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .scandata  (scandata),
    .scan_valid(scan_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_held       = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!r_on[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_on[i] && (r_code[i] == scandata)) w_held = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_on         <= '0;
      r_code       <= {NUM_VOICES{VOICE_IDLE}};
      r_break_pend <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_steal_ptr  <= '0;
    end else if (all_off) begin
      r_on         <= '0;
      r_code       <= {NUM_VOICES{VOICE_IDLE}};
      r_break_pend <= 1'b0;
      r_ext_pend   <= 1'b0;
    end else if (scan_valid) begin
      if (scandata == PS2_BREAK) begin
        r_break_pend <= 1'b1;
      end else if (scandata == PS2_EXT) begin
        r_ext_pend <= 1'b1;
      end else if (r_ext_pend) begin
        // Extended keys never drive voices; the byte just closes the sequence.
        r_ext_pend   <= 1'b0;
        r_break_pend <= 1'b0;
      end else if (r_break_pend) begin
        r_break_pend <= 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_on[i] && (r_code[i] == scandata)) begin
            r_on[i]   <= 1'b0;
            r_code[i] <= VOICE_IDLE;
          end
        end
      end else if (is_music_key(scandata) && !w_held) begin
        if (w_free_found) begin
          r_on[w_free_idx]   <= 1'b1;
          r_code[w_free_idx] <= scandata;
        end else if (STEAL != 0) begin
          r_on[r_steal_ptr]   <= 1'b1;
          r_code[r_steal_ptr] <= scandata;
          r_steal_ptr <= (r_steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
        end
      end
    end
  end

  assign voice_on   = r_on;
  assign voice_code = r_code;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - scoreboard bench for ps2_key_tracker (drop and steal variants)
module tb_ps2_key_tracker;

  localparam int HALF = 20;
  localparam int GAP  = 60;
  localparam int TO   = 500;

  logic        sys_clk = 1'b0;
  logic        reset, ps2_clk, ps2_dat, all_off;
  logic [7:0]  sd_a, sd_b;
  logic        sv_a, pe_a, fe_a, sv_b, pe_b, fe_b;
  logic [3:0]  von_a, von_b;
  logic [31:0] vcode_a, vcode_b;

  always #5 sys_clk = ~sys_clk;

  ps2_key_tracker #(.NUM_VOICES(4), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .STEAL(0)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .all_off(all_off),
    .scandata(sd_a), .scan_valid(sv_a), .parity_err(pe_a), .frame_err(fe_a),
    .voice_on(von_a), .voice_code(vcode_a));

  ps2_key_tracker #(.NUM_VOICES(4), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .STEAL(1)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .all_off(all_off),
    .scandata(sd_b), .scan_valid(sv_b), .parity_err(pe_b), .frame_err(fe_b),
    .voice_on(von_b), .voice_code(vcode_b));

  typedef struct {
    int          id;
    logic [1:0]  kind;   // 0 scan_valid, 1 parity_err, 2 frame_err
    logic [7:0]  data;
    logic [3:0]  on_a;
    logic [31:0] code_a;
    logic [3:0]  on_b;
    logic [31:0] code_b;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          step     = 0;
  logic [3:0]  x_on_a, x_on_b;
  logic [31:0] x_code_a, x_code_b;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_v(input logic [3:0] on_a, input logic [31:0] code_a,
                       input logic [3:0] on_b, input logic [31:0] code_b);
    x_on_a = on_a; x_code_a = code_a; x_on_b = on_b; x_code_b = code_b;
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
    exp_t e;
    e.id = step; e.kind = kind; e.data = data;
    e.on_a = x_on_a; e.code_a = x_code_a; e.on_b = x_on_b; e.code_b = x_code_b;
    exp_q.push_back(e);
    step++;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input logic arm_off);
    logic par;
    bit   seen;
    par = (~^b) ^ par_flip;
    push_exp(!stop_bit ? 2'd2 : (par_flip ? 2'd1 : 2'd0), b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_dat = stop_bit;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    if (arm_off) begin
      seen = 1'b0;
      for (int i = 0; i < 4 * HALF && !seen; i++) begin
        @(negedge sys_clk);
        if (sv_a) seen = 1'b1;
      end
      chk("all_off_sync_scan_valid_seen", step - 1, 32'(seen), 32'd1);
      if (seen) begin
        all_off = 1'b1;
        @(posedge sys_clk);
        #1 all_off = 1'b0;
      end
    end
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send_truncated();
    push_exp(2'd2, 8'h00);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(TO + 200);
  endtask

  // Monitor: pops one expectation per output pulse, then checks the voice table next cycle.
  initial begin : monitor
    exp_t       e;
    logic [2:0] req_p;
    forever begin
      @(negedge sys_clk);
      if (!reset && (sv_a || pe_a || fe_a || sv_b || pe_b || fe_b)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", -1, 32'({sv_a, pe_a, fe_a}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          req_p = (e.kind == 2'd0) ? 3'b100 : (e.kind == 2'd1) ? 3'b010 : 3'b001;
          chk("pulses_a", e.id, 32'({sv_a, pe_a, fe_a}), 32'(req_p));
          chk("pulses_b", e.id, 32'({sv_b, pe_b, fe_b}), 32'(req_p));
          if (e.kind == 2'd0) begin
            chk("scandata_a", e.id, 32'(sd_a), 32'(e.data));
            chk("scandata_b", e.id, 32'(sd_b), 32'(e.data));
          end
          @(negedge sys_clk);
          chk("voice_on_a", e.id, 32'(von_a), 32'(e.on_a));
          chk("voice_code_a", e.id, vcode_a, e.code_a);
          chk("voice_on_b", e.id, 32'(von_b), 32'(e.on_b));
          chk("voice_code_b", e.id, vcode_b, e.code_b);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    int waited;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; all_off = 1'b0;
    set_v(4'b0000, 32'hF0F0F0F0, 4'b0000, 32'hF0F0F0F0);
    wait_cyc(5);
    @(negedge sys_clk);
    chk("reset_scandata", -1, 32'(sd_a), 32'h00);
    chk("reset_pulses", -1, 32'({sv_a, pe_a, fe_a, sv_b, pe_b, fe_b}), 32'd0);
    chk("reset_voice_on", -1, 32'({von_a, von_b}), 32'd0);
    chk("reset_voice_code_a", -1, vcode_a, 32'hF0F0F0F0);
    chk("reset_voice_code_b", -1, vcode_b, 32'hF0F0F0F0);
    @(posedge sys_clk); #1 reset = 1'b0;
    wait_cyc(20);

    // Fill all four slots, then overflow: a drops, b steals slot 0 then slot 1.
    set_v(4'b0001, 32'hF0F0F01C, 4'b0001, 32'hF0F0F01C); send_frame(8'h1C, 0, 1, 0);
    set_v(4'b0011, 32'hF0F01B1C, 4'b0011, 32'hF0F01B1C); send_frame(8'h1B, 0, 1, 0);
    set_v(4'b0111, 32'hF0231B1C, 4'b0111, 32'hF0231B1C); send_frame(8'h23, 0, 1, 0);
    set_v(4'b1111, 32'h2B231B1C, 4'b1111, 32'h2B231B1C); send_frame(8'h2B, 0, 1, 0);
    set_v(4'b1111, 32'h2B231B1C, 4'b1111, 32'h2B231B34); send_frame(8'h34, 0, 1, 0);
    set_v(4'b1111, 32'h2B231B1C, 4'b1111, 32'h2B231C34); send_frame(8'h1C, 0, 1, 0);
    // all_off coincides with a voice update and must win.
    set_v(4'b0000, 32'hF0F0F0F0, 4'b0000, 32'hF0F0F0F0); send_frame(8'h1D, 0, 1, 1);
    // Break releases slot 0; next make reuses it.
    set_v(4'b0001, 32'hF0F0F01C, 4'b0001, 32'hF0F0F01C); send_frame(8'h1C, 0, 1, 0);
    set_v(4'b0011, 32'hF0F01B1C, 4'b0011, 32'hF0F01B1C); send_frame(8'h1B, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    set_v(4'b0010, 32'hF0F01BF0, 4'b0010, 32'hF0F01BF0); send_frame(8'h1C, 0, 1, 0);
    set_v(4'b0011, 32'hF0F01B23, 4'b0011, 32'hF0F01B23); send_frame(8'h23, 0, 1, 0);
    // Extended key, errors and timeout leave voices alone.
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_truncated();
    set_v(4'b0111, 32'hF0151B23, 4'b0111, 32'hF0151B23); send_frame(8'h15, 0, 1, 0);
    // Typematic repeat, non-music key, break of an untracked key.
    send_frame(8'h1B, 0, 1, 0);
    send_frame(8'h5A, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h34, 0, 1, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge sys_clk);
      waited++;
    end
    wait_cyc(4);
    chk("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
